// File: rtl/microwave_cook_controller.sv
// Microwave cook-cycle sequencer: BCD keypad entry, 1 Hz countdown, door interlock,
// pause/resume and a timed end-of-cook beep. All outputs are registered.
module microwave_cook_controller #(
  parameter int QUICK_SEC  = 30,
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic       magnetron_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       done,
  output logic       beep
);

  localparam int CNT_W = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TICKS - 1);
  localparam logic [15:0] QUICK_TIME = {8'h00, 4'(QUICK_SEC / 10), 4'(QUICK_SEC % 10)};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      time_q, time_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_prev_q, stop_prev_q;
  logic             magnetron_on_q, done_q, beep_q;
  logic             start_edge, stop_edge;
  logic [15:0]      time_dec;

  // Time is {min_tens, min_ones, sec_tens, sec_ones}; seconds above 59 are never normalised.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      so = 4'd9;
      st = st - 4'd1;
    end else begin
      so = 4'd9;
      st = 4'd5;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 4'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign start_edge = start & ~start_prev_q;
  assign stop_edge  = stop_clear & ~stop_prev_q;
  assign time_dec   = bcd_dec(time_q);

  // Events are tested in priority order: stop edge, door open, start edge, tick, digit.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_SET: begin
        if (stop_edge) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (start_edge && door_closed && state_q == S_IDLE) begin
          state_d = S_COOK;
          time_d  = QUICK_TIME;
        end else if (start_edge && door_closed && time_q != '0) begin
          state_d = S_COOK;
        end else if (digit_valid && digit <= 4'd9) begin
          state_d = S_SET;
          time_d  = {time_q[11:0], digit};
        end
      end
      S_COOK: begin
        if (stop_edge || !door_closed) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          time_d = time_dec;
          if (time_dec == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end
      S_PAUSE: begin
        if (stop_edge) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (start_edge && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_edge || !door_closed) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      time_q         <= '0;
      cnt_q          <= '0;
      start_prev_q   <= 1'b0;
      stop_prev_q    <= 1'b0;
      magnetron_on_q <= 1'b0;
      done_q         <= 1'b0;
      beep_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      time_q         <= time_d;
      cnt_q          <= cnt_d;
      start_prev_q   <= start;
      stop_prev_q    <= stop_clear;
      magnetron_on_q <= (state_d == S_COOK);
      done_q         <= (state_d == S_DONE);
      beep_q         <= (state_d == S_DONE);
    end
  end

  assign magnetron_on = magnetron_on_q;
  assign done         = done_q;
  assign beep         = beep_q;
  assign min_tens     = time_q[15:12];
  assign min_ones     = time_q[11:8];
  assign sec_tens     = time_q[7:4];
  assign sec_ones     = time_q[3:0];

endmodule

// File: doc/microwave_cook_controller.md
Name: microwave_cook_controller

Overview:
- Sequences one microwave cook cycle: keypad time entry (MM:SS, BCD), countdown paced by the 1 Hz tick pulse from the team's frequency-divider chain, magnetron enable, door interlock, pause/resume and end-of-cook beep.
- Sits between the keypad/door inputs and the magnetron driver and 7-segment display decoders.
- Consumes the divider's single-cycle tick output as a clock enable; never generates clocks.

Parameters:
- QUICK_SEC, 30, seconds loaded by a start press from IDLE (BCD 00:30 at default; range 1-59)
- DONE_TICKS, 3, number of tick pulses the beep and done indication last

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle pulse, 1 Hz, from the frequency divider
- digit  input  4  keypad digit value
- digit_valid  input  1  one-cycle strobe qualifying digit
- start  input  1  start/resume button level (synchronous)
- stop_clear  input  1  stop/clear button level (synchronous)
- door_closed  input  1  1 = door closed
- magnetron_on  output  1  magnetron enable
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display time
- done  output  1  high throughout DONE state
- beep  output  1  buzzer enable

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. Reset drives state IDLE, all four digits 0, magnetron_on 0, done 0, beep 0, edge-detect registers 0.
- start and stop_clear are rising-edge detected internally (registered previous value). A held button acts once.
- States: IDLE, SET, COOK, PAUSE, DONE. All outputs are registered. magnetron_on is 1 exactly in the cycles when the state is COOK.
- Event priority within a cycle: stop_clear edge > door open > start edge > tick > digit_valid.
- Digit entry, accepted in IDLE and SET only:
  - On digit_valid with digit<=9: shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit); IDLE->SET.
  - A fifth digit discards the oldest.
  - digit>9 is ignored.
  - digit_valid is ignored in all other states.
- IDLE:
  - start edge with door_closed: load 00:QUICK_SEC, ->COOK.
  - start edge with door open: no effect.
- SET:
  - start edge with door_closed and time nonzero: ->COOK.
  - start edge with time 0000: ignored.
  - stop_clear edge: clear digits, ->IDLE.
- COOK:
  - On tick, decrement BCD time. If sec_ones>0, decrement sec_ones. Else if sec_tens>0, sec_ones=9 and sec_tens-1. Else seconds become 59 and minutes borrow the same way (min_ones, then min_tens).
  - Seconds above 59 as entered (e.g. 0090) count down as plain BCD (90,89,...). They are not normalised.
  - A tick that brings the time to 0000 sends the next state to DONE, with the display at 0000.
  - Door open, or stop_clear edge: ->PAUSE. The time holds, and magnetron_on drops on the next edge.
  - A tick in the same cycle as door open or stop_clear is not applied.
- PAUSE:
  - Ticks ignored.
  - start edge with door_closed: ->COOK. A tick in that same cycle is not applied.
  - stop_clear edge: clear digits, ->IDLE.
- DONE:
  - done=1 and beep=1.
  - An internal counter counts ticks. After DONE_TICKS ticks: ->IDLE, done=0, beep=0, digits remain 0000.
  - stop_clear edge or door open exits to IDLE immediately.
- Reset asserted mid-cook forces IDLE and magnetron_on=0 asynchronously, without waiting for clk.

Test Plan:
- Reset, then digits 1,3,0 and a start edge with door closed -> display 01:30 and COOK the cycle after. After 1 tick -> 01:29. After 30 ticks total -> 01:00. After 31 -> 00:59.
- Enter 0,0,0,2, start, then 2 ticks -> 00:01, then 00:00. DONE asserted with magnetron_on=0. beep=1 for 3 ticks, then IDLE with done=0.
- During COOK at 00:45, open the door in the same cycle as a tick -> PAUSE next cycle, magnetron_on=0, display stays 00:45. Ticks while paused change nothing. Close the door and start -> COOK resumes from 00:45.
- Start with door closed in IDLE -> 00:30 COOK. Start held high for 10 cycles -> only one start is seen. stop_clear edge -> PAUSE. Second stop_clear edge -> IDLE with 00:00.
- Enter 0,0,9,0 and cook for 1 tick -> 00:89. Enter 1,2,3,4,5 -> 23:45. digit=12 strobe -> ignored. Start with time 0000 in SET -> no transition.
- Assert rst asynchronously mid-COOK between clk edges -> magnetron_on=0 and all digits 0 before the next edge.
